// File: rtl/nba_pkg.sv
// Shared types and constants for the number-baseball referee.
// The NBA_QCHECK_EN build uses question_ok() to reject malformed questions.
package nba_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int MAX_CNT    = 200;
  localparam int CNT_W      = 16;

  localparam logic [2:0] INVALID_SCORE = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    REPLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A legal question uses decimal digits only, each at most once.
  function automatic logic question_ok(input logic [NUM_DIGITS*DIGIT_W-1:0] q);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ok = ok & (q[i*DIGIT_W +: DIGIT_W] <= 4'd9);
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        ok = ok & (q[i*DIGIT_W +: DIGIT_W] != q[j*DIGIT_W +: DIGIT_W]);
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/nba_digit_cmp.sv
// Scores one question digit against the whole answer: strike if it sits in
// the same position, otherwise ball if it appears anywhere else.
module nba_digit_cmp #(
  parameter int NUM_DIGITS = nba_pkg::NUM_DIGITS,
  parameter int IDX_W      = 2
) (
  input  logic [nba_pkg::DIGIT_W-1:0]            q_digit,
  input  logic [IDX_W-1:0]                       idx,
  input  logic [NUM_DIGITS*nba_pkg::DIGIT_W-1:0] answer,
  output logic                                   is_strike,
  output logic                                   is_ball
);
  import nba_pkg::*;

  logic hit_same_s;
  logic hit_other_s;

  // Same-position match and any match at another position.
  always_comb begin
    hit_same_s  = (answer[idx*DIGIT_W +: DIGIT_W] == q_digit);
    hit_other_s = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      hit_other_s = hit_other_s |
                    ((IDX_W'(j) != idx) && (answer[j*DIGIT_W +: DIGIT_W] == q_digit));
    end
  end

  assign is_strike = hit_same_s;
  assign is_ball   = !hit_same_s && hit_other_s;

endmodule

// File: rtl/nba_referee.sv
// Number-baseball referee: accepts a question, scores it one digit per cycle,
// and replies with strike/ball/count. Optional macro: NBA_QCHECK_EN.
module nba_referee #(
  parameter int NUM_DIGITS = nba_pkg::NUM_DIGITS,
  parameter int MAX_CNT    = nba_pkg::MAX_CNT,
  parameter int CNT_W      = nba_pkg::CNT_W
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_DIGITS*nba_pkg::DIGIT_W-1:0] answer,
  input  logic [NUM_DIGITS*nba_pkg::DIGIT_W-1:0] question,
  input  logic                                   ask_valid,
  output logic                                   ask_ready,
  output logic [2:0]                             strike,
  output logic [2:0]                             ball,
  output logic [CNT_W-1:0]                       cnt,
  output logic                                   correct,
  output logic                                   reply_valid,
  input  logic                                   reply_ready
);
  import nba_pkg::*;

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int QW    = NUM_DIGITS * DIGIT_W;

  state_t              state_r, next_state_s;
  logic [QW-1:0]       answer_r, question_r;
  logic [IDX_W-1:0]    idx_r;
  logic [2:0]          strike_acc_r, ball_acc_r;
  logic [2:0]          strike_next_s, ball_next_s;
  logic [DIGIT_W-1:0]  q_digit_s;
  logic                is_strike_s, is_ball_s;
  logic                accept_s, reply_fire_s, last_cmp_s, q_valid_s;
  logic [CNT_W-1:0]    cnt_inc_s;

`ifdef NBA_QCHECK_EN
  assign q_valid_s = question_ok(question);
`else
  assign q_valid_s = 1'b1;
`endif

  assign accept_s      = ask_valid && ask_ready && (state_r == IDLE);
  assign reply_fire_s  = reply_valid && reply_ready;
  assign last_cmp_s    = (idx_r == IDX_W'(NUM_DIGITS - 1));
  assign q_digit_s     = question_r[idx_r*DIGIT_W +: DIGIT_W];
  assign strike_next_s = strike_acc_r + {2'b00, is_strike_s};
  assign ball_next_s   = ball_acc_r + {2'b00, is_ball_s};
  assign cnt_inc_s     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  nba_digit_cmp #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (IDX_W)
  ) u_cmp (
    .q_digit   (q_digit_s),
    .idx       (idx_r),
    .answer    (answer_r),
    .is_strike (is_strike_s),
    .is_ball   (is_ball_s)
  );

  // Round sequencing: IDLE -> CMP (or straight to REPLY when rejected) -> REPLY -> IDLE/DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = q_valid_s ? CMP : REPLY;
        end else begin
          next_state_s = IDLE;
        end
      end
      CMP: begin
        if (last_cmp_s) begin
          next_state_s = REPLY;
        end else begin
          next_state_s = CMP;
        end
      end
      REPLY: begin
        if (reply_fire_s) begin
          if (correct || (cnt == CNT_W'(MAX_CNT))) begin
            next_state_s = DONE;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = REPLY;
        end
      end
      DONE:    next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, scoring datapath and registered handshake outputs; reply_valid
  // trails entry into REPLY by one cycle so scores are settled first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      answer_r     <= answer;
      question_r   <= '0;
      idx_r        <= '0;
      strike_acc_r <= 3'd0;
      ball_acc_r   <= 3'd0;
      ask_ready    <= 1'b0;
      reply_valid  <= 1'b0;
      strike       <= 3'd0;
      ball         <= 3'd0;
      cnt          <= '0;
      correct      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      ask_ready   <= (next_state_s == IDLE);
      reply_valid <= (state_r == REPLY) && !reply_fire_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            question_r   <= question;
            idx_r        <= '0;
            strike_acc_r <= 3'd0;
            ball_acc_r   <= 3'd0;
            if (!q_valid_s) begin
              strike  <= INVALID_SCORE;
              ball    <= INVALID_SCORE;
              correct <= 1'b0;
              cnt     <= cnt_inc_s;
            end
          end
        end
        CMP: begin
          strike_acc_r <= strike_next_s;
          ball_acc_r   <= ball_next_s;
          idx_r        <= idx_r + IDX_W'(1);
          if (last_cmp_s) begin
            strike  <= strike_next_s;
            ball    <= ball_next_s;
            correct <= (strike_next_s == 3'(NUM_DIGITS));
            cnt     <= cnt_inc_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/nba_referee.md
Name: nba_referee

Overview:
- Responder end of the number-baseball ask/reply protocol; the solver is the initiator.
- Holds a secret 4-digit hex answer and accepts questions over the ask handshake.
- For each question it scores strikes and balls over four compare cycles and returns the result over the reply handshake, with a running question count.
- Flags a correct guess, and stops the round after MAX_CNT questions.

Parameters:
- NUM_DIGITS, 4, digits per answer/question (4 bits each)
- MAX_CNT, 200, question limit; round ends after this many replies
- CNT_W, 16, width of cnt

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears round state and samples answer
- answer  in  16  secret; digit i = answer[4i+3:4i]
- question  in  16  solver's guess, same digit layout
- ask_valid  in  1  question valid
- ask_ready  out  1  referee can accept a question
- strike  out  3  digits equal in same position (0..4)
- ball  out  3  digits present in answer at a different position (0..4)
- cnt  out  16  replies issued this round
- correct  out  1  current/last reply had strike==4; sticky until reset
- reply_valid  out  1  strike/ball/cnt/correct valid
- reply_ready  in  1  solver consumes reply

Behaviour:
- Reset values (any cycle, including mid-operation):
  - outputs: ask_ready=0, reply_valid=0, strike=0, ball=0, cnt=0, correct=0
  - state=IDLE; an in-flight question is discarded
  - answer_q<=answer on every edge with reset=1; answer is ignored while reset=0
- IDLE:
  - ask_ready=1
  - on ask_valid&&ask_ready: latch question into question_q, clear accumulators, idx=0, go to CMP
- CMP (exactly NUM_DIGITS cycles):
  - each cycle, digit q=question_q[idx] is compared with all answer_q digits
  - +1 strike if q==answer_q[idx]
  - else +1 ball if q equals any answer_q[j] with j!=idx; at most one ball per question digit
  - idx increments; after idx==NUM_DIGITS-1, go to REPLY
- Entering REPLY:
  - strike/ball registered
  - cnt<=cnt+1, saturating at 2^CNT_W-1
  - correct<=(strike==NUM_DIGITS)
- REPLY:
  - reply_valid=1; outputs held stable until reply_ready
  - on reply_valid&&reply_ready:
    - to DONE if correct or cnt==MAX_CNT
    - else to IDLE
- DONE:
  - ask_ready=0, reply_valid=0
  - strike/ball/cnt/correct hold until reset
- Latency: handshake accepted at edge T -> reply_valid=1 after edge T+NUM_DIGITS+1 (5 cycles at default).
- ask_ready=0 outside IDLE; ask_valid is ignored then. Back-to-back questions are allowed: reply accepted at edge T -> ask_ready=1 after T.
- Repeated question digits are scored per question digit; no deduplication unless the optional feature is enabled.

Optional Feature:
- NBA_QCHECK_EN
- Defined:
  - a question is invalid if any digit >9 or any two question digits are equal
  - invalid questions skip CMP and reply one cycle after acceptance with strike=7, ball=7, correct=0
  - cnt still increments, and the MAX_CNT rule still applies
- Undefined: all questions are scored as described; no 7/7 reply is ever produced.

Decomposition:
- Package nba_pkg:
  - NUM_DIGITS, DIGIT_W=4, MAX_CNT default, CNT_W
  - state enum {IDLE, CMP, REPLY, DONE}
  - INVALID_SCORE=3'd7
- Sub-module nba_digit_cmp (combinational): inputs one question digit, its index, and the full answer; outputs is_strike, is_ball. Instantiated once and shared across CMP cycles.

Test Plan:
- Exact match: answer=16'h1234 via reset, question=16'h1234 -> reply after 5 cycles with strike=4, ball=0, cnt=1, correct=1; after reply_ready, DONE with ask_ready=0.
- Partial scores, answer=16'h1234:
  - question 16'h4321 -> 0/4
  - question 16'h1243 -> 2/2
  - question 16'h5678 -> 0/0
  - cnt reads 1, 2, 3 across the three replies
- Backpressure: hold reply_ready=0 for 3 cycles -> reply_valid stays 1, outputs stable, ask_ready=0; reply_ready=1 -> IDLE next cycle.
- Timeout: 200 wrong questions (16'h5678) -> 200th reply has cnt=200, correct=0; then DONE, ask_ready stays 0, further ask_valid ignored.
- Reset during CMP (after 2 compare cycles), new answer 16'h9876 -> all outputs 0, IDLE; question 16'h9876 -> strike=4, cnt=1.
- NBA_QCHECK_EN, question 16'h1123 -> reply 1 cycle after accept with strike=7, ball=7, cnt incremented; question 16'h12A4 -> same 7/7 response.
